// File: rtl/cordic_issue_controller.sv
// Issue sequencer for a single-instruction-in-flight CORDIC pipeline.
// Accepts a 16-bit packet, issues it to Fetch with a one-cycle stall release,
// waits for the CORDIC result (with timeout), chains tan/tanh into a second
// division pass, and writes one or two results back to the register file.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-low reset
//   instr_valid/_packet   : upstream packet {op, x_addr, y_addr, z_addr}
//   instr_ready           : high only while idle
//   fetch_packet/_stall   : packet and stall to the Fetch stage
//   chain_sel/_x/_y       : second-pass operand override for the CORDIC
//   cordic_done/_x/_y/_z  : CORDIC result pulse and values
//   wb_en/_addr/_data     : register-file write port
//   busy, error           : status; error is sticky until the next accept
module cordic_issue_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [15:0]       instr_packet,
    output logic              instr_ready,
    output logic [15:0]       fetch_packet,
    output logic              fetch_stall,
    output logic              chain_sel,
    output logic [DATA_W-1:0] chain_x,
    output logic [DATA_W-1:0] chain_y,
    input  logic              cordic_done,
    input  logic [DATA_W-1:0] cordic_x,
    input  logic [DATA_W-1:0] cordic_y,
    input  logic [DATA_W-1:0] cordic_z,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] OP_SIN_COS   = 4'd0;
    localparam logic [3:0] OP_SINH_COSH = 4'd1;
    localparam logic [3:0] OP_EXP       = 4'd4;
    localparam logic [3:0] OP_SQR_ROOT  = 4'd5;
    localparam logic [3:0] OP_DIVISION  = 4'd6;
    localparam logic [3:0] OP_TAN       = 4'd7;
    localparam logic [3:0] OP_TANH      = 4'd8;
    localparam logic [3:0] OP_HYPOT     = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_WB1, S_WB2
    } state_e;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= 4'd10) && (op != 4'd9);
    endfunction

    function automatic logic is_two_pass(input logic [3:0] op);
        return (op == OP_TAN) || (op == OP_TANH);
    endfunction

    function automatic logic is_dual_wb(input logic [3:0] op);
        return (op == OP_SIN_COS) || (op == OP_SINH_COSH);
    endfunction

    // Ops whose single/first writeback is the x result to x_addr; others write z to z_addr.
    function automatic logic writes_x(input logic [3:0] op);
        return (op == OP_SIN_COS) || (op == OP_SINH_COSH) || (op == OP_EXP) ||
               (op == OP_SQR_ROOT) || (op == OP_HYPOT);
    endfunction

    state_e              state_q, state_d;
    logic [15:0]         pkt_q, pkt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   y_hold_q, y_hold_d;
    logic                ready_q, ready_d;
    logic [15:0]         fetch_packet_q, fetch_packet_d;
    logic                fetch_stall_q, fetch_stall_d;
    logic                chain_sel_q, chain_sel_d;
    logic [DATA_W-1:0]   chain_x_q, chain_x_d;
    logic [DATA_W-1:0]   chain_y_q, chain_y_d;
    logic                wb_en_q, wb_en_d;
    logic [3:0]          wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    logic [3:0] op;
    logic [3:0] in_op;
    logic       accept;
    logic       timeout_hit;

    assign op          = pkt_q[15:12];
    assign in_op       = instr_packet[15:12];
    assign accept      = instr_valid && ready_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        pkt_d          = pkt_q;
        cnt_d          = '0;
        y_hold_d       = y_hold_q;
        fetch_packet_d = fetch_packet_q;
        chain_x_d      = chain_x_q;
        chain_y_d      = chain_y_q;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        error_d        = error_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pkt_d   = instr_packet;
                    error_d = !is_legal(in_op);
                    if (is_legal(in_op)) begin
                        state_d = S_ISSUE1;
                        // First pass of tan/tanh is the matching sin_cos/sinh_cosh
                        if (in_op == OP_TAN)
                            fetch_packet_d = {OP_SIN_COS, instr_packet[11:0]};
                        else if (in_op == OP_TANH)
                            fetch_packet_d = {OP_SINH_COSH, instr_packet[11:0]};
                        else
                            fetch_packet_d = instr_packet;
                    end
                end
            end
            S_ISSUE1: state_d = S_WAIT1;
            S_ISSUE2: state_d = S_WAIT2;
            S_WAIT1, S_WAIT2: begin
                if (cordic_done) begin
                    if ((state_q == S_WAIT1) && is_two_pass(op)) begin
                        chain_x_d      = cordic_x;
                        chain_y_d      = cordic_y;
                        fetch_packet_d = {OP_DIVISION, pkt_q[11:0]};
                        state_d        = S_ISSUE2;
                    end else begin
                        wb_addr_d = writes_x(op) ? pkt_q[11:8] : pkt_q[3:0];
                        wb_data_d = writes_x(op) ? cordic_x : cordic_z;
                        y_hold_d  = cordic_y;
                        state_d   = S_WB1;
                    end
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB1: begin
                if (is_dual_wb(op)) begin
                    wb_addr_d = pkt_q[7:4];
                    wb_data_d = y_hold_q;
                    state_d   = S_WB2;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB2:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d       = (state_d == S_IDLE);
        fetch_stall_d = !((state_d == S_ISSUE1) || (state_d == S_ISSUE2));
        chain_sel_d   = (state_d == S_ISSUE2) || (state_d == S_WAIT2);
        wb_en_d       = (state_d == S_WB1) || (state_d == S_WB2);
        busy_d        = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            pkt_q          <= '0;
            cnt_q          <= '0;
            y_hold_q       <= '0;
            ready_q        <= 1'b0;
            fetch_packet_q <= '0;
            fetch_stall_q  <= 1'b1;
            chain_sel_q    <= 1'b0;
            chain_x_q      <= '0;
            chain_y_q      <= '0;
            wb_en_q        <= 1'b0;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pkt_q          <= pkt_d;
            cnt_q          <= cnt_d;
            y_hold_q       <= y_hold_d;
            ready_q        <= ready_d;
            fetch_packet_q <= fetch_packet_d;
            fetch_stall_q  <= fetch_stall_d;
            chain_sel_q    <= chain_sel_d;
            chain_x_q      <= chain_x_d;
            chain_y_q      <= chain_y_d;
            wb_en_q        <= wb_en_d;
            wb_addr_q      <= wb_addr_d;
            wb_data_q      <= wb_data_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
        end
    end

    assign instr_ready  = ready_q;
    assign fetch_packet = fetch_packet_q;
    assign fetch_stall  = fetch_stall_q;
    assign chain_sel    = chain_sel_q;
    assign chain_x      = chain_x_q;
    assign chain_y      = chain_y_q;
    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule

// File: doc/cordic_issue_controller.md
Name: cordic_issue_controller

Overview:
- Sequences instruction packets into the Fetch stage and the CORDIC core, one instruction in flight at a time.
- Drives Fetch's stall so that each pass loads exactly once, and waits for CORDIC completion.
- Chains two-pass ops: tan is sin_cos then division; tanh is sinh_cosh then division.
- Writes results back to the register file and flags illegal opcodes and CORDIC timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for cordic_done per pass before aborting.
- DATA_W, 32: operand/result width (IEEE-754 single).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  upstream packet valid.
- instr_packet  in  16  {opcode[15:12], x_addr[11:8], y_addr[7:4], z_addr[3:0]}.
- instr_ready  out  1  controller can accept a packet.
- fetch_packet  out  16  packet presented to Fetch.
- fetch_stall  out  1  Fetch stall; 0 for exactly one cycle per pass.
- chain_sel  out  1  1 = CORDIC x/y inputs come from chain_x/chain_y instead of Fetch.
- chain_x  out  DATA_W  pass-2 divisor (pass-1 x result).
- chain_y  out  DATA_W  pass-2 dividend (pass-1 y result).
- cordic_done  in  1  one-cycle result-valid pulse from CORDIC.
- cordic_x, cordic_y, cordic_z  in  DATA_W  CORDIC results.
- wb_en  out  1  register-file write strobe.
- wb_addr  out  4  write address.
- wb_data  out  DATA_W  write data.
- busy  out  1  state != IDLE.
- error  out  1  sticky: illegal opcode or timeout; cleared on the next accepted packet.

Behaviour:
- Reset values: state IDLE, instr_ready=0 in the reset cycle then 1, fetch_stall=1, fetch_packet=0, chain_sel=0, chain_x=0, chain_y=0, wb_en=0, wb_addr=0, wb_data=0, busy=0, error=0, timeout counter=0.
- Legal opcodes are 0–8 and 10. Opcodes 9 and 11–15 are illegal:
  - they are accepted but dropped, and error=1;
  - no issue and no writeback occur;
  - the controller returns to IDLE the next cycle.
- The packet is latched on instr_valid && instr_ready. instr_ready=1 only in IDLE.
- States:
  - IDLE → ISSUE1 on accept of a legal packet.
  - ISSUE1: fetch_stall=0 for one cycle. fetch_packet = original packet, except tan → opcode 0 and tanh → opcode 1. Then → WAIT1.
  - WAIT1: fetch_stall=1; counter increments each cycle.
    - On cordic_done with a tan/tanh op: capture chain_x=cordic_x, chain_y=cordic_y, → ISSUE2.
    - On cordic_done otherwise → WB1.
  - ISSUE2: fetch_packet opcode=6 (division), chain_sel=1, fetch_stall=0 for one cycle. → WAIT2.
  - WAIT2: chain_sel stays 1 until done. On cordic_done → WB1.
  - WB1: wb_en=1 for one cycle. For sin_cos/sinh_cosh → WB2, otherwise → IDLE.
  - WB2: wb_en=1, wb_addr=y_addr, wb_data=cordic_y (captured at done). → IDLE.
- WB1 result mapping:
  - sin_cos/sinh_cosh: x_addr ← x result.
  - arctan/arctanh/division/tan/tanh: z_addr ← z result.
  - exp/sqr_root/hypotenuse: x_addr ← x result.
- All results are registered at the cordic_done edge; the CORDIC may change its outputs afterwards.
- Timeout: the counter clears on entry to WAIT1/WAIT2. When it reaches TIMEOUT_CYCLES without done: error=1, no writeback, → IDLE.
- cordic_done outside WAIT1/WAIT2 is ignored.
- Latency: accept at cycle 0, fetch_stall low at cycle 1, done at cycle N, wb_en at N+1 (and N+2 for WB2).
  - Two-pass ops: done1 at N1, ISSUE2 at N1+1, wb_en one cycle after done2.
- Reset asserted mid-operation returns to IDLE with reset values; the in-flight result is discarded and any later done is ignored.
- instr_valid held high while busy causes no accept and no packet loss; the packet is taken on the cycle after returning to IDLE.

Test Plan:
- Reset, then packet 0x0003 (sin_cos, z=3); done at cycle 10 with x=0x3F5A8279, y=0x3F0A8BD4 → cycle 11 wb x_addr0←0x3F5A8279, cycle 12 wb y_addr0←0x3F0A8BD4; fetch_stall low only at cycle 1.
- Packet 0x7123 (tan); done1 with x=0x3F800000, y=0x3F000000 → fetch_packet 0x0123 then 0x6123 with chain_sel=1, chain_x=0x3F800000, chain_y=0x3F000000; done2 z=0x3F000000 → wb addr3 ←0x3F000000.
- Packet 0xB000 → error=1, no fetch_stall pulse, no wb_en, instr_ready back at 1 next cycle; next packet 0x6456 clears error.
- Packet 0x6456 with no done for TIMEOUT_CYCLES → error=1 at the timeout cycle, no wb_en, return to IDLE; a late done is ignored.
- reset low during WAIT1 of 0x8123 → all outputs at reset values next cycle; a subsequent done produces no wb_en.
- Back-to-back: instr_valid held with 0x2010 then 0x5120 → second accepted only after WB1 of the first; writes go to addr0 (z) and then addr1 (x).
